// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: pipeline stage, instruction classes,
// load/store size codes and FSM states.
package lsu_pkg;

  localparam logic [2:0] LSU_STAGE = 3'd4;

  localparam logic [4:0] RTYPE  = 5'd0;
  localparam logic [4:0] ITYPE  = 5'd1;
  localparam logic [4:0] STYPE  = 5'd2;
  localparam logic [4:0] LTYPE  = 5'd3;
  localparam logic [4:0] BTYPE  = 5'd4;
  localparam logic [4:0] UTYPE  = 5'd5;
  localparam logic [4:0] JRTYPE = 5'd6;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} lsu_state_e;

  // Legal size code with natural alignment; unsigned sizes exist only for loads.
  function automatic logic access_ok(input logic [2:0] funct3, input logic [1:0] off,
                                     input logic is_store);
    case (funct3)
      F3_B:    return 1'b1;
      F3_BU:   return !is_store;
      F3_H:    return !off[0];
      F3_HU:   return !is_store && !off[0];
      F3_W:    return off == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_extract.sv
// Load lane selection and sign/zero extension of a returned memory word.
module lsu_extract
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    unique case (offset_i)
      2'd0: byte_v = rdata_i[7:0];
      2'd1: byte_v = rdata_i[15:8];
      2'd2: byte_v = rdata_i[23:16];
      2'd3: byte_v = rdata_i[31:24];
    endcase
    half_v = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (funct3_i)
      F3_B:    data_o = {{24{byte_v[7]}}, byte_v};
      F3_H:    data_o = {{16{half_v[15]}}, half_v};
      F3_BU:   data_o = {24'd0, byte_v};
      F3_HU:   data_o = {16'd0, half_v};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: issues one memory access per stage-4 entry, with alignment
// checking, byte-lane steering, ack timeout and writeback.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  stage_i,
  input  logic [4:0]  itype_i,
  input  logic [31:0] ir_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] wb_data_o,
  output logic        wb_valid_o,
  output logic        busy_o,
  output logic        fault_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  lsu_state_e state_q, state_d;
  logic            stage_q;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [2:0]      f3_q, f3_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [3:0]      mem_be_q, mem_be_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;
  logic [31:0]     wb_data_q, wb_data_d;
  logic            wb_valid_q, wb_valid_d;
  logic            fault_q, fault_d;

  logic        stage_hit;
  logic        is_mem;
  logic        is_store;
  logic [2:0]  funct3;
  logic [3:0]  be_calc;
  logic [31:0] st_data;
  logic [31:0] ld_data;

  logic unused_ir;
  assign unused_ir = ^{ir_i[31:15], ir_i[11:0]};

  assign funct3    = ir_i[14:12];
  assign is_store  = (itype_i == STYPE);
  assign is_mem    = is_store || (itype_i == LTYPE);
  // Act only on the first cycle of a stage match, not while it is held.
  assign stage_hit = (stage_i == LSU_STAGE) && !stage_q;

  lsu_extract u_extract (
    .rdata_i  (rdata_q),
    .offset_i (addr_q[1:0]),
    .funct3_i (f3_q),
    .data_o   (ld_data)
  );

  always_comb begin
    case (f3_q[1:0])
      2'b00: begin
        be_calc = 4'b0001 << addr_q[1:0];
        st_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be_calc = 4'b0011 << addr_q[1:0];
        st_data = {2{wdata_q[15:0]}};
      end
      default: begin
        be_calc = 4'b1111;
        st_data = wdata_q;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    f3_d        = f3_q;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    wb_data_d   = wb_data_q;
    wb_valid_d  = 1'b0;
    fault_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (stage_hit) begin
          if (!is_mem) begin
            wb_data_d  = addr_i;
            wb_valid_d = 1'b1;
          end else if (access_ok(funct3, addr_i[1:0], is_store)) begin
            we_d    = is_store;
            addr_d  = addr_i;
            wdata_d = wdata_i;
            f3_d    = funct3;
            state_d = StReq;
          end else begin
            fault_d = 1'b1;
          end
        end
      end
      StReq: begin
        mem_req_d   = 1'b1;
        mem_we_d    = we_q;
        mem_addr_d  = {addr_q[31:2], 2'b00};
        mem_be_d    = be_calc;
        mem_wdata_d = st_data;
        cnt_d       = '0;
        state_d     = StWait;
      end
      StWait: begin
        if (mem_ack_i || cnt_q == CntLast) begin
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_be_d    = '0;
          mem_wdata_d = '0;
          if (mem_ack_i) begin
            rdata_d = mem_rdata_i;
            state_d = StDone;
          end else begin
            fault_d = 1'b1;
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        wb_valid_d = 1'b1;
        if (!we_q) wb_data_d = ld_data;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      stage_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      f3_q        <= '0;
      rdata_q     <= '0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      wb_data_q   <= '0;
      wb_valid_q  <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      stage_q     <= (stage_i == LSU_STAGE);
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      f3_q        <= f3_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      wb_data_q   <= wb_data_d;
      wb_valid_q  <= wb_valid_d;
      fault_q     <= fault_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_be_o    = mem_be_q;
  assign mem_wdata_o = mem_wdata_q;
  assign wb_data_o   = wb_data_q;
  assign wb_valid_o  = wb_valid_q;
  assign fault_o     = fault_q;
  assign busy_o      = (state_q == StReq) || (state_q == StWait);

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for the load/store unit.
module tb_lsu;
  import lsu_pkg::*;

  logic        clk;
  logic        reset;
  logic [2:0]  stage_i;
  logic [4:0]  itype_i;
  logic [31:0] ir_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] wb_data_o;
  logic        wb_valid_o;
  logic        busy_o;
  logic        fault_o;

  int n_checks = 0;
  int n_fail   = 0;

  lsu #(.TIMEOUT(15)) dut (
    .clk         (clk),
    .reset       (reset),
    .stage_i     (stage_i),
    .itype_i     (itype_i),
    .ir_i        (ir_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_be_o    (mem_be_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .wb_data_o   (wb_data_o),
    .wb_valid_o  (wb_valid_o),
    .busy_o      (busy_o),
    .fault_o     (fault_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one stage-4 cycle, then drop the stage; returns one cycle after the trigger edge.
  task automatic issue(input logic [4:0] it, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    @(negedge clk);
    stage_i = LSU_STAGE;
    itype_i = it;
    ir_i    = {17'd0, f3, 12'd0};
    addr_i  = a;
    wdata_i = wd;
    @(negedge clk);
    stage_i = 3'd0;
  endtask

  task automatic test_reset;
    #1;
    n_checks++;
    if ({mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o, wb_data_o, wb_valid_o,
         busy_o, fault_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: req=%b we=%b addr=%h be=%b wd=%h wb=%h v=%b busy=%b f=%b, want all 0",
               mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o, wb_data_o, wb_valid_o,
               busy_o, fault_o);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_rtype;
    issue(RTYPE, 3'd0, 32'h0000_0055, 32'h0);
    n_checks++;
    if (wb_valid_o !== 1'b1 || wb_data_o !== 32'h55 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rtype_wb: valid=%b data=%h busy=%b, want 1 00000055 0",
               wb_valid_o, wb_data_o, busy_o);
    end
    @(negedge clk);
    n_checks++;
    if (wb_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rtype_pulse: valid=%b, want 0", wb_valid_o);
    end
  endtask

  task automatic test_held_stage;
    int pulses = 0;
    @(negedge clk);
    stage_i = LSU_STAGE;
    itype_i = ITYPE;
    addr_i  = 32'h11;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (wb_valid_o === 1'b1) pulses++;
    end
    stage_i = 3'd0;
    @(negedge clk);
    n_checks++;
    if (pulses != 1 || wb_data_o !== 32'h11) begin
      n_fail++;
      $display("FAIL held_stage: pulses=%0d data=%h, want 1 00000011", pulses, wb_data_o);
    end
  endtask

  task automatic test_lw;
    issue(LTYPE, F3_W, 32'h100, 32'h0);
    @(negedge clk);
    n_checks++;
    if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 32'h100 ||
        mem_be_o !== 4'b1111 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL lw_req: req=%b we=%b addr=%h be=%b busy=%b, want 1 0 00000100 1111 1",
               mem_req_o, mem_we_o, mem_addr_o, mem_be_o, busy_o);
    end
    @(negedge clk);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hDEAD_BEEF;
    n_checks++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h100 || mem_be_o !== 4'b1111) begin
      n_fail++;
      $display("FAIL lw_hold: req=%b addr=%h be=%b, want 1 00000100 1111",
               mem_req_o, mem_addr_o, mem_be_o);
    end
    @(negedge clk);
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'h0;
    n_checks++;
    if (mem_req_o !== 1'b0 || wb_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL lw_drop: req=%b valid=%b, want 0 0", mem_req_o, wb_valid_o);
    end
    @(negedge clk);
    n_checks++;
    if (wb_valid_o !== 1'b1 || wb_data_o !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL lw_wb: valid=%b data=%h, want 1 deadbeef", wb_valid_o, wb_data_o);
    end
    @(negedge clk);
    n_checks++;
    if (wb_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL lw_pulse: valid=%b busy=%b, want 0 0", wb_valid_o, busy_o);
    end
  endtask

  task automatic test_lb_lbu;
    logic [2:0]  f3s [2] = '{F3_B, F3_BU};
    logic [31:0] exps[2] = '{32'hFFFF_FF80, 32'h0000_0080};
    for (int i = 0; i < 2; i++) begin
      issue(LTYPE, f3s[i], 32'h103, 32'h0);
      @(negedge clk);
      n_checks++;
      if (mem_req_o !== 1'b1 || mem_be_o !== 4'b1000 || mem_addr_o !== 32'h100) begin
        n_fail++;
        $display("FAIL lb_req[%0d]: req=%b be=%b addr=%h, want 1 1000 00000100",
                 i, mem_req_o, mem_be_o, mem_addr_o);
      end
      mem_ack_i   = 1'b1;
      mem_rdata_i = 32'h8000_0000;
      @(negedge clk);
      mem_ack_i = 1'b0;
      @(negedge clk);
      n_checks++;
      if (wb_valid_o !== 1'b1 || wb_data_o !== exps[i]) begin
        n_fail++;
        $display("FAIL lb_wb[%0d]: valid=%b data=%h, want 1 %h", i, wb_valid_o, wb_data_o, exps[i]);
      end
    end
  endtask

  task automatic test_sh;
    issue(STYPE, F3_H, 32'h202, 32'h1234_ABCD);
    @(negedge clk);
    n_checks++;
    if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_be_o !== 4'b1100 ||
        mem_wdata_o !== 32'hABCD_ABCD || mem_addr_o !== 32'h200) begin
      n_fail++;
      $display("FAIL sh_req: req=%b we=%b be=%b wd=%h addr=%h, want 1 1 1100 abcdabcd 00000200",
               mem_req_o, mem_we_o, mem_be_o, mem_wdata_o, mem_addr_o);
    end
    mem_ack_i = 1'b1;
    @(negedge clk);
    mem_ack_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (wb_valid_o !== 1'b1 || wb_data_o !== 32'h0000_0080) begin
      n_fail++;
      $display("FAIL sh_wb: valid=%b data=%h, want 1 00000080", wb_valid_o, wb_data_o);
    end
  endtask

  task automatic test_misaligned;
    logic [4:0]  its[4] = '{LTYPE, LTYPE, STYPE, LTYPE};
    logic [2:0]  f3s[4] = '{F3_W, F3_H, F3_BU, 3'b011};
    logic [31:0] as [4] = '{32'h101, 32'h201, 32'h200, 32'h200};
    for (int i = 0; i < 4; i++) begin
      issue(its[i], f3s[i], as[i], 32'h0);
      n_checks++;
      if (fault_o !== 1'b1 || mem_req_o !== 1'b0 || wb_valid_o !== 1'b0 || busy_o !== 1'b0) begin
        n_fail++;
        $display("FAIL bad_access[%0d]: fault=%b req=%b valid=%b busy=%b, want 1 0 0 0",
                 i, fault_o, mem_req_o, wb_valid_o, busy_o);
      end
      @(negedge clk);
      n_checks++;
      if (fault_o !== 1'b0 || mem_req_o !== 1'b0 || wb_valid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL bad_access_after[%0d]: fault=%b req=%b valid=%b, want 0 0 0",
                 i, fault_o, mem_req_o, wb_valid_o);
      end
    end
  endtask

  task automatic test_ack_ignored;
    @(negedge clk);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h5555_AAAA;
    @(negedge clk);
    mem_ack_i = 1'b0;
    n_checks++;
    if (wb_valid_o !== 1'b0 || mem_req_o !== 1'b0 || busy_o !== 1'b0 || fault_o !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_ack: valid=%b req=%b busy=%b fault=%b, want 0 0 0 0",
               wb_valid_o, mem_req_o, busy_o, fault_o);
    end
    @(negedge clk);
    n_checks++;
    if (wb_valid_o !== 1'b0 || wb_data_o !== 32'h0000_0080) begin
      n_fail++;
      $display("FAIL stray_ack_wb: valid=%b data=%h, want 0 00000080", wb_valid_o, wb_data_o);
    end
  endtask

  task automatic test_timeout;
    int req_cycles = 0;
    int faults     = 0;
    int wbs        = 0;
    issue(LTYPE, F3_W, 32'h300, 32'h0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req_o === 1'b1) req_cycles++;
      if (fault_o === 1'b1) begin
        faults++;
        n_checks++;
        if (mem_req_o !== 1'b0) begin
          n_fail++;
          $display("FAIL timeout_fault_req: req=%b during fault, want 0", mem_req_o);
        end
      end
      if (wb_valid_o === 1'b1) wbs++;
    end
    n_checks++;
    if (req_cycles != 15 || faults != 1 || wbs != 0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout: req_cycles=%0d faults=%0d wb=%0d busy=%b, want 15 1 0 0",
               req_cycles, faults, wbs, busy_o);
    end
  endtask

  task automatic test_reset_mid;
    issue(LTYPE, F3_W, 32'h400, 32'h0);
    @(negedge clk);
    n_checks++;
    if (mem_req_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_pre: req=%b, want 1", mem_req_o);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (mem_req_o !== 1'b0 || busy_o !== 1'b0 || wb_valid_o !== 1'b0 || wb_data_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_async: req=%b busy=%b valid=%b data=%h, want 0 0 0 0",
               mem_req_o, busy_o, wb_valid_o, wb_data_o);
    end
    @(negedge clk);
    reset = 1'b0;
    issue(RTYPE, 3'd0, 32'h7, 32'h0);
    n_checks++;
    if (wb_valid_o !== 1'b1 || wb_data_o !== 32'h7 || mem_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_then_rtype: valid=%b data=%h req=%b, want 1 00000007 0",
               wb_valid_o, wb_data_o, mem_req_o);
    end
  endtask

  initial begin
    reset       = 1'b1;
    stage_i     = 3'd0;
    itype_i     = RTYPE;
    ir_i        = 32'h0;
    addr_i      = 32'h0;
    wdata_i     = 32'h0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'h0;

    test_reset();
    test_rtype();
    test_held_stage();
    test_lw();
    test_lb_lbu();
    test_sh();
    test_misaligned();
    test_ack_ignored();
    test_timeout();
    test_reset_mid();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter TIMEOUT, default 15, max cycles to wait for mem_ack_i before abort.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 stage_i  in  3  pipeline stage counter; this block acts when stage_i==4.
REQ-005 itype_i  in  5  instruction class from the shared itype encoding (RTYPE, ITYPE, STYPE, LTYPE, BTYPE, UTYPE, JRTYPE).
REQ-006 ir_i  in  32  current instruction; funct3 = ir_i[14:12].
REQ-007 addr_i  in  32  ALU result (effective address or plain result).
REQ-008 wdata_i  in  32  ALU pass-through operand (store data).
REQ-009 mem_req_o  out  1  memory request, held until acknowledged.
REQ-010 mem_we_o  out  1  1 = write, 0 = read.
REQ-011 mem_addr_o  out  32  word address: {addr_i[31:2],2'b00}.
REQ-012 mem_be_o  out  4  byte enables.
REQ-013 mem_wdata_o  out  32  store data, replicated into lanes.
REQ-014 mem_ack_i  in  1  one-cycle acknowledge; mem_rdata_i valid in the same cycle.
REQ-015 mem_rdata_i  in  32  read word.
REQ-016 wb_data_o  out  32  writeback value.
REQ-017 wb_valid_o  out  1  one-cycle pulse, wb_data_o valid.
REQ-018 busy_o  out  1  high while in REQ or WAIT state.
REQ-019 fault_o  out  1  one-cycle pulse on misalignment or timeout.

Function
REQ-020 FSM states: IDLE, REQ, WAIT, DONE; reset state IDLE.
REQ-021 IDLE: sample inputs only on the first cycle stage_i==4 (edge of stage match); ignore a held stage_i==4.
REQ-022 Non-memory itype at stage 4: wb_data_o<=addr_i, wb_valid_o pulses next cycle, FSM stays IDLE.
REQ-023 LTYPE/STYPE: latch addr_i, wdata_i, funct3, direction; go to REQ.
REQ-024 Sizes: funct3 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned (load only).
REQ-025 Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or illegal funct3: no memory request; fault_o pulses; wb_valid_o stays low; return to IDLE.
REQ-026 REQ: assert mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o; go to WAIT in the same cycle as the request is raised.
REQ-027 WAIT: hold all mem_* outputs stable until mem_ack_i; a wait counter increments each cycle.
REQ-028 mem_ack_i in WAIT: drop mem_req_o next cycle; go to DONE.
REQ-029 Counter reaching TIMEOUT without ack: drop mem_req_o; pulse fault_o; return to IDLE; no writeback.
REQ-030 Byte enables: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
REQ-031 Store data: byte replicated in 4 lanes; half replicated in 2 lanes; word as-is.
REQ-032 Load extract: select lane by addr[1:0]; sign-extend for 000/001; zero-extend for 100/101.
REQ-033 DONE: loads drive wb_data_o with extracted data and pulse wb_valid_o; stores pulse wb_valid_o with wb_data_o unchanged; return to IDLE.
REQ-034 mem_ack_i outside WAIT is ignored.

Reset
REQ-035 Asserting reset forces IDLE immediately and clears all outputs to 0, including mid-transaction; a pending request is dropped with no writeback.

Structure
REQ-036 Stage number 4, funct3 load/store codes and FSM state encodings belong in the shared opcode/itype include files.
REQ-037 Load lane extraction/extension is one combinational sub-module, lsu_extract.

Verification
REQ-038 LW addr 0x100, ack after 2 cycles with rdata 0xDEADBEEF -> be=1111, wb_data_o=0xDEADBEEF, one wb_valid_o pulse.
REQ-039 LB addr 0x103, rdata 0x80000000 -> be=1000, wb_data_o=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-040 SH addr 0x202, wdata 0x1234ABCD -> mem_we_o=1, be=1100, mem_wdata_o=0xABCDABCD.
REQ-041 LW addr 0x101 -> no mem_req_o, fault_o pulses, no wb_valid_o.
REQ-042 LW with no ack -> mem_req_o held 15 cycles then dropped, fault_o pulses, FSM returns to IDLE.
REQ-043 Reset asserted in WAIT -> mem_req_o low asynchronously; after release, an RTYPE with addr_i=7 gives wb_data_o=7.
